matrix_column_scanner: RTL and testbench
========================================

# matrix_column_scanner

Time-multiplexed driver for the kit's 5×7 LED matrix. It sits directly downstream of the image decoders, which produce two 7-bit column images: col_1 for outer columns 0/4 and col_0 for inner columns 1/2/3. The block snapshots the image once per frame, scans the five columns one at a time with an anti-ghosting dead time, and supports frame-locked blinking and blanking.

## Interface
- DIV, 1000: clock cycles per column slot; DIV ≥ 2.
- DEAD, 50: cycles at the start of each slot with all columns off; 0 ≤ DEAD < DIV.
- BLINK_FRAMES, 50: frames per blink half-period; ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- col_1  in  7  image for columns 0 and 4; bit k maps to row k.
- col_0  in  7  image for columns 1, 2 and 3.
- blank  in  1  forces display dark; scan continues.
- blink_en  in  1  enables frame-locked blinking.
- col_n  out  5  column select, one-hot active-low.
- row  out  7  row drive, active-high.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

## Operation
- State:
  - prescaler p: 0..DIV-1.
  - column index c: 0..4.
  - snapshot registers img1, img0: 7 bits each.
  - frame counter f: 0..BLINK_FRAMES-1.
  - blink phase b: 1 = visible.
- Every cycle p increments. At p = DIV-1, p wraps to 0 and c advances, with 4 wrapping to 0.
- Frame boundary is the c 4→0 transition. On that edge:
  - img1 ← col_1 and img0 ← col_0.
  - frame_tick is asserted.
  - f increments. When f wraps, b toggles.
- Inputs are sampled only at frame boundaries. Mid-frame input changes are invisible until the next frame.
- Visibility: vis = !blank && (!blink_en || b). f and b advance regardless of blink_en.
- Output rules, all registered:
  - If !vis or p < DEAD: col_n = 5'b11111 and row = 0.
  - Otherwise: col_n = ~(1 << c); row = img1 when c ∈ {0, 4}, else img0.
- Reset values (async, immediate, also mid-frame):
  - p = 0, c = 0, f = 0, b = 1.
  - img1 = img0 = 0.
  - col_n = 5'b11111, row = 0, frame_tick = 0.
- The first frame after reset displays the zero image and has no frame_tick.

## Timing
- All outputs are registered and updated on the same edge as the state. They reflect the slot (c, p) just entered.
- Edge 1 after reset release enters slot (0, 0).
- Frame length is 5·DIV cycles. The first frame_tick occurs on edge 5·DIV+1. It coincides with slot (0, 0) of the new frame, and the new snapshot is already on row in that frame.
- A blank or blink_en change takes effect on the next edge. Counters are never disturbed by it.
- When DEAD = 0 there is no dark gap; column changes are direct.
- Blink period is 2·BLINK_FRAMES frames. The phase toggles on a frame_tick edge.
- Simultaneous frame boundary and blank: the snapshot still happens and outputs go dark.

## Structure
- Package matrix_pkg holds:
  - NUM_COLS = 5 and NUM_ROWS = 7.
  - Typedefs col_idx_t (3 bits) and row_t (7 bits).
  - Function col_onehot_n(col_idx_t) returning the active-low select.
- Sub-module scan_timer (parameter DIV) owns p and c and emits slot_wrap and frame_wrap strobes.
- The top level owns the snapshot, blink and output registers.
- Expected size is roughly 150–250 RTL lines.

## Test plan
Bench parameters: DIV=4, DEAD=1, BLINK_FRAMES=2.

- **Reset:** hold rst_n=0 with random inputs. Expect col_n=5'b11111, row=0, frame_tick=0. Then release and check that frame_tick first rises on edge 21.
- **Scan mapping:** col_1=7'h7F, col_0=7'h01, with blank=0 and blink_en=0. In frame 2, each slot gives 1 dark cycle, then 3 cycles of:
  - col_n=11110 with row=7F,
  - 11101 with 01,
  - 11011 with 01,
  - 10111 with 01,
  - 01111 with 7F.
- **Snapshot:** change col_0 to 7'h3C during slot c=2. Rows stay 01 for the rest of the frame and show 3C from the next frame_tick.
- **Blink:** blink_en=1. Expect 2 frames visible, 2 frames dark (col_n=11111, row=0), then repeat. frame_tick keeps pulsing every 20 cycles throughout.
- **Blank:** assert blank for 3 cycles mid-slot. Outputs go dark on the next edge and recover on the edge after deassertion, and frame_tick timing is unchanged.
- **Reset mid-frame:** pull rst_n low at c=3, p=2. Outputs are reset immediately without a clock. After release, the scan restarts at slot (0, 0) with the zero image.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared geometry, types and column-select helper for the 5x7 LED matrix scanner.
package matrix_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;

    typedef logic [2:0]          col_idx_t;
    typedef logic [NUM_ROWS-1:0] row_t;

    function automatic logic [NUM_COLS-1:0] col_onehot_n(input col_idx_t c);
        logic [NUM_COLS-1:0] w_one;
        w_one    = '0;
        w_one[0] = 1'b1;
        return ~(w_one << c);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot prescaler and column counter; strobes mark the edge that enters a new slot / frame.
// Strobes are combinational from the counter state; free-running, no backpressure.
module scan_timer
    import matrix_pkg::*;
#(
    parameter int DIV = 1000,
    parameter int PW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [PW-1:0] o_p,
    output col_idx_t      o_c,
    output logic          o_slot_wrap,
    output logic          o_frame_wrap
);

    logic [PW-1:0] r_p;
    col_idx_t      r_c;
    logic          r_run;
    logic          w_last_p;
    logic          w_last_c;

    assign w_last_p = (r_p == PW'(DIV - 1));
    assign w_last_c = (r_c == col_idx_t'(NUM_COLS - 1));

    // r_p/r_c name the slot entered on the coming edge; r_run keeps the very
    // first entry into slot (0,0) after reset from counting as a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_c   <= '0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_last_p) begin
                r_p <= '0;
                r_c <= w_last_c ? '0 : r_c + 1'b1;
            end else begin
                r_p <= r_p + 1'b1;
            end
        end
    end

    assign o_p          = r_p;
    assign o_c          = r_c;
    assign o_slot_wrap  = r_run && (r_p == '0);
    assign o_frame_wrap = o_slot_wrap && (r_c == '0);

endmodule

// File: rtl/matrix_column_scanner.sv
// Time-multiplexed 5x7 matrix driver: per-frame image snapshot, dead-time, blink and blank.
// All outputs registered, reflecting the slot entered on the same edge; free-running.
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int DIV          = 1000,
    parameter int DEAD         = 50,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] col_1,
    input  logic [NUM_ROWS-1:0] col_0,
    input  logic                blank,
    input  logic                blink_en,
    output logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row,
    output logic                frame_tick
);

    localparam int PW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] w_p;
    col_idx_t      w_c;
    logic          w_slot_wrap;
    logic          w_frame_wrap;

    row_t                r_img1;
    row_t                r_img0;
    row_t                r_slot_img;
    logic [FW-1:0]       r_f;
    logic                r_b;
    logic [NUM_COLS-1:0] r_col_n;
    row_t                r_row;
    logic                r_frame_tick;

    row_t                w_img1_nxt;
    row_t                w_img0_nxt;
    row_t                w_slot_img_nxt;
    logic [FW-1:0]       w_f_nxt;
    logic                w_f_last;
    logic                w_b_nxt;
    logic                w_outer;
    logic                w_vis;
    logic                w_dead;
    logic                w_dark;

    scan_timer #(
        .DIV (DIV),
        .PW  (PW)
    ) u_scan_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_p          (w_p),
        .o_c          (w_c),
        .o_slot_wrap  (w_slot_wrap),
        .o_frame_wrap (w_frame_wrap)
    );

    // Next-state values are used for the outputs too, so the new snapshot and
    // the toggled blink phase already apply to the boundary cycle itself.
    always_comb begin
        w_img1_nxt     = r_img1;
        w_img0_nxt     = r_img0;
        w_f_nxt        = r_f;
        w_b_nxt        = r_b;
        w_f_last       = (r_f == FW'(BLINK_FRAMES - 1));
        if (w_frame_wrap) begin
            w_img1_nxt = col_1;
            w_img0_nxt = col_0;
            w_f_nxt    = w_f_last ? '0 : r_f + 1'b1;
            w_b_nxt    = w_f_last ? ~r_b : r_b;
        end
        w_outer        = (w_c == '0) || (w_c == col_idx_t'(NUM_COLS - 1));
        w_slot_img_nxt = r_slot_img;
        if (w_slot_wrap) begin
            w_slot_img_nxt = w_outer ? w_img1_nxt : w_img0_nxt;
        end
        w_vis  = !blank && (!blink_en || w_b_nxt);
        w_dead = (DEAD > 0) && (w_p < PW'(DEAD));
        w_dark = !w_vis || w_dead;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_img1       <= '0;
            r_img0       <= '0;
            r_slot_img   <= '0;
            r_f          <= '0;
            r_b          <= 1'b1;
            r_col_n      <= '1;
            r_row        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_img1       <= w_img1_nxt;
            r_img0       <= w_img0_nxt;
            r_slot_img   <= w_slot_img_nxt;
            r_f          <= w_f_nxt;
            r_b          <= w_b_nxt;
            r_col_n      <= w_dark ? '1 : col_onehot_n(w_c);
            r_row        <= w_dark ? '0 : w_slot_img_nxt;
            r_frame_tick <= w_frame_wrap;
        end
    end

    assign col_n      = r_col_n;
    assign row        = r_row;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Randomized and directed bench for matrix_column_scanner against a slot/frame arithmetic model.
module tb_matrix_column_scanner;

    localparam int DIV   = 4;
    localparam int DEAD  = 1;
    localparam int BF    = 2;
    localparam int FRAME = 5 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] col_1;
    logic [6:0] col_0;
    logic       blank;
    logic       blink_en;
    logic [4:0] col_n;
    logic [6:0] row;
    logic       frame_tick;

    int n_err    = 0;
    int n_checks = 0;
    int edge_n   = 0;

    logic [6:0] m_img1;
    logic [6:0] m_img0;
    int         m_s, m_c, m_p, m_fr;
    bit         m_vis;
    logic       e_tick;
    logic [4:0] e_coln;
    logic [6:0] e_row;

    logic [4:0] coln_tab [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    logic [6:0] row_tab  [5] = '{7'h7F, 7'h01, 7'h01, 7'h01, 7'h7F};

    always #5 clk = ~clk;

    matrix_column_scanner #(
        .DIV          (DIV),
        .DEAD         (DEAD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_1      (col_1),
        .col_0      (col_0),
        .blank      (blank),
        .blink_en   (blink_en),
        .col_n      (col_n),
        .row        (row),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    task automatic wait_edge(input int k);
        int guard;
        guard = 0;
        while (edge_n != k && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (edge_n != k) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_edge: reached edge %0d, wanted %0d", edge_n, k);
        end
    endtask

    task automatic chk_out(input string name, input logic [4:0] cn, input logic [6:0] r);
        chk({name, "_col_n"}, 32'(col_n), 32'(cn));
        chk({name, "_row"}, 32'(row), 32'(r));
    endtask

    // Reference: slot index s = edges since release - 1; everything follows by division.
    always @(posedge clk) begin
        if (!rst_n) begin
            edge_n = 0;
            m_img1 = '0;
            m_img0 = '0;
            e_tick = 1'b0;
            e_coln = 5'h1F;
            e_row  = '0;
        end else begin
            edge_n++;
            m_s    = edge_n - 1;
            m_p    = m_s % DIV;
            m_c    = (m_s / DIV) % 5;
            m_fr   = m_s / FRAME;
            e_tick = (m_s > 0) && (m_s % FRAME == 0);
            if (e_tick) begin
                m_img1 = col_1;
                m_img0 = col_0;
            end
            m_vis = !blank && (!blink_en || ((m_fr / BF) % 2 == 0));
            if (!m_vis || m_p < DEAD) begin
                e_coln = 5'h1F;
                e_row  = '0;
            end else begin
                e_coln = 5'h1F & ~(5'b00001 << m_c);
                e_row  = (m_c == 0 || m_c == 4) ? m_img1 : m_img0;
            end
        end
        #1;
        chk("mdl_col_n", 32'(col_n), 32'(e_coln));
        chk("mdl_row", 32'(row), 32'(e_row));
        chk("mdl_frame_tick", 32'(frame_tick), 32'(e_tick));
    end

    initial begin
        int first_tick;
        rst_n    = 1'b1;
        col_1    = 7'($urandom);
        col_0    = 7'($urandom);
        blank    = 1'($urandom);
        blink_en = 1'($urandom);
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            col_1    = 7'($urandom);
            col_0    = 7'($urandom);
            blank    = 1'($urandom);
            blink_en = 1'($urandom);
        end
        chk_out("reset", 5'b11111, 7'h00);
        chk("reset_tick", 32'(frame_tick), 32'd0);

        col_1    = 7'h7F;
        col_0    = 7'h01;
        blank    = 1'b0;
        blink_en = 1'b0;
        rst_n    = 1'b1;

        first_tick = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick) begin
                first_tick = i;
                break;
            end
        end
        chk("first_tick_edge", 32'(first_tick), 32'd21);

        for (int c = 0; c < 5; c++) begin
            wait_edge(21 + 4 * c);
            chk_out("scan_dead", 5'b11111, 7'h00);
            if (c == 2) col_0 = 7'h3C;
            wait_edge(22 + 4 * c);
            chk_out("scan_lit", coln_tab[c], row_tab[c]);
        end
        wait_edge(41);
        chk("snap_tick", 32'(frame_tick), 32'd1);
        wait_edge(46);
        chk_out("snap_new", 5'b11101, 7'h3C);

        wait_edge(80);
        blink_en = 1'b1;
        wait_edge(82);
        chk_out("blink_vis", 5'b11110, 7'h7F);
        wait_edge(121);
        chk("blink_tick", 32'(frame_tick), 32'd1);
        wait_edge(122);
        chk_out("blink_dark", 5'b11111, 7'h00);
        wait_edge(162);
        chk_out("blink_back", 5'b11110, 7'h7F);
        wait_edge(170);
        blink_en = 1'b0;

        wait_edge(182);
        blank = 1'b1;
        wait_edge(183);
        chk_out("blank_on", 5'b11111, 7'h00);
        wait_edge(185);
        blank = 1'b0;
        wait_edge(186);
        chk_out("blank_off", 5'b11101, 7'h3C);
        wait_edge(200);
        chk("blank_tick_before", 32'(frame_tick), 32'd0);
        wait_edge(201);
        chk("blank_tick", 32'(frame_tick), 32'd1);

        repeat (500) begin
            @(posedge clk);
            #1;
            col_1 = 7'($urandom);
            col_0 = 7'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
        end

        blank    = 1'b0;
        blink_en = 1'b0;
        for (int i = 0; i < 40 && (edge_n % FRAME) != 15; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_slot", 32'(edge_n % FRAME), 32'd15);
        #3 rst_n = 1'b0;
        #1;
        chk_out("midrst_async", 5'b11111, 7'h00);
        chk("midrst_tick", 32'(frame_tick), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        col_1 = 7'h7F;
        col_0 = 7'h01;
        rst_n = 1'b1;
        wait_edge(1);
        chk_out("restart_dead", 5'b11111, 7'h00);
        wait_edge(2);
        chk_out("restart_c0", 5'b11110, 7'h00);
        wait_edge(6);
        chk_out("restart_c1", 5'b11101, 7'h00);
        wait_edge(20);
        chk("restart_tick_before", 32'(frame_tick), 32'd0);
        wait_edge(21);
        chk("restart_tick", 32'(frame_tick), 32'd1);
        wait_edge(22);
        chk_out("restart_img", 5'b11110, 7'h7F);

        repeat (4) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
